io_ring_pwr_seq: RTL and testbench
==================================

Name: io_ring_pwr_seq

Overview:
- Digital power sequencer that sits directly upstream of the IO-ring rail cells (rail-short, pad and supply cells).
- Qualifies the asynchronous core-rail and IO-rail power-good indications and sequences the ring up and down: isolation release, then pad enable, then ready.
- Forces a safe state (isolated, pads off) on any rail loss and latches a fault until software clears it.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for the async power-good inputs; legal range 2..4.
- STABLE_CYCLES, 1024, consecutive cycles both rails must be good before sequencing starts; must be ≥ 2.
- STEP_CYCLES, 16, dwell cycles between consecutive sequencing steps; must be ≥ 1.
- CNT_W, $clog2(max(STABLE_CYCLES,STEP_CYCLES)), derived width of the shared counter; do not override.

Ports:
- clk  in  1  single block clock.
- rst  in  1  synchronous, active-high reset.
- vdd_ok_async  in  1  core-rail power-good; asynchronous to clk.
- vddio_ok_async  in  1  IO-rail power-good; asynchronous to clk.
- req_on  in  1  level request to power the ring up; 0 requests power-down.
- fault_clr  in  1  single-cycle pulse that clears a latched fault.
- io_iso  out  1  1 = ring outputs clamped/isolated.
- io_pad_en  out  1  1 = pad drivers enabled.
- pwr_ready  out  1  1 = ring fully up.
- fault  out  1  sticky rail-loss flag.
- state  out  3  encoded FSM state, for debug/status only.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=OFF, io_iso=1, io_pad_en=0, pwr_ready=0, fault=0, counter=0, all synchroniser flops=0.
- Synchronisers: rails_ok = (SYNC_STAGES-flop sync of vdd_ok_async) AND (same for vddio_ok_async). Async edge to FSM reaction is SYNC_STAGES+1 clocks.
- Registered outputs: all outputs are registered. Each output changes on the same edge as the state transition into its state. No combinational input-to-output paths.
- State encodings: OFF=0, DEBOUNCE=1, REL_ISO=2, EN_PADS=3, ON=4, SHUTDOWN=5, FAULT=6.
- OFF:
  - Outputs: io_iso=1, io_pad_en=0, pwr_ready=0.
  - req_on & rails_ok → DEBOUNCE; counter cleared.
- DEBOUNCE:
  - Counter increments each cycle.
  - !rails_ok or !req_on → OFF, with no fault (rails not yet trusted).
  - counter==STABLE_CYCLES-1 → REL_ISO.
- REL_ISO:
  - io_iso=0 on entry.
  - Counter counts STEP_CYCLES, then → EN_PADS.
- EN_PADS:
  - io_pad_en=1 on entry.
  - Counter counts STEP_CYCLES, then → ON.
- ON:
  - pwr_ready=1 on entry.
  - !req_on → SHUTDOWN.
- SHUTDOWN:
  - On entry: io_pad_en=0 and pwr_ready=0.
  - After STEP_CYCLES, io_iso=1 and → OFF.
  - Power-down order is the mirror of power-up (pads off before isolation re-asserted).
- Rail loss (!rails_ok) in REL_ISO, EN_PADS, ON or SHUTDOWN → FAULT.
  - Next edge: io_iso=1, io_pad_en=0, pwr_ready=0, fault=1.
  - No stepped shutdown on rail loss.
- FAULT:
  - Outputs held safe.
  - Exits to OFF only on fault_clr & !req_on; fault=0 on that edge.
  - fault_clr while req_on=1 is ignored and the fault stays latched.
- Simultaneous events:
  - Rail loss outranks req_on deassertion, which outranks counter expiry.
  - rst outranks everything, including mid-sequence: outputs go to their reset values on the next edge.
- Re-request during SHUTDOWN (req_on back to 1): the shutdown completes to OFF first. No reversal mid-step.
- Counter rules:
  - Cleared on every state entry.
  - Saturates, never wraps.
  - Compares use CNT_W-bit unsigned arithmetic.

Decomposition:
- Shared package io_ring_pkg holds:
  - state enum typedef io_seq_state_e (3 bits, encodings above);
  - default constants IO_SEQ_STABLE_CYCLES and IO_SEQ_STEP_CYCLES;
  - the SYNC_STAGES legal-range constants.
- One natural sub-module: io_ring_sync, a parameterised N-flop reset-to-0 synchroniser, instantiated once per power-good input.

Test Plan:
- Power-up with STABLE_CYCLES=8, STEP_CYCLES=4, SYNC_STAGES=2: after reset, drive both rails=1 and req_on=1 at edge 0.
  → DEBOUNCE at edge 3, io_iso falls at edge 11, io_pad_en rises at edge 15, pwr_ready rises at edge 19, fault stays 0.
- Debounce glitch: drop vddio_ok_async for 3 cycles at debounce count 5.
  → Return to OFF, no fault, io_iso stays 1. Sequence restarts and reaches ON 16 cycles after the glitch clears plus sync latency.
- Rail loss in ON: deassert vdd_ok_async.
  → Exactly 3 edges later io_pad_en=0, io_iso=1, pwr_ready=0, fault=1, state=6.
  → fault_clr with req_on=1 is ignored; fault_clr with req_on=0 gives state=0 and fault=0.
- Orderly power-down: from ON, drop req_on.
  → Next edge io_pad_en=0 and pwr_ready=0; 4 edges later io_iso=1 and state=0.
- Simultaneous events: rail loss and req_on deassert on the same synchronised cycle in ON → FAULT, not SHUTDOWN.
- Reset mid-sequence: assert rst during EN_PADS → outputs 1/0/0/0 (io_iso/io_pad_en/pwr_ready/fault) and state=0 on the next edge.

Source files
------------

// File: rtl/io_ring_pkg.sv
// Shared definitions for the IO-ring power sequencer.
// Contents:
//   io_seq_state_e          - sequencer state encoding, also exported on the status port
//   IO_SEQ_STABLE_CYCLES    - default rail-stable qualification time
//   IO_SEQ_STEP_CYCLES      - default dwell between sequencing steps
//   IO_SEQ_SYNC_STAGES_MIN/MAX - legal synchroniser depth range
//   max_u()                 - helper for sizing the shared counter
package io_ring_pkg;

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StDebounce = 3'd1,
    StRelIso   = 3'd2,
    StEnPads   = 3'd3,
    StOn       = 3'd4,
    StShutdown = 3'd5,
    StFault    = 3'd6
  } io_seq_state_e;

  localparam int unsigned IO_SEQ_STABLE_CYCLES   = 1024;
  localparam int unsigned IO_SEQ_STEP_CYCLES     = 16;
  localparam int unsigned IO_SEQ_SYNC_STAGES_MIN = 2;
  localparam int unsigned IO_SEQ_SYNC_STAGES_MAX = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/io_ring_pwr_seq_if.sv
// Control/status bundle between a power-management controller and the IO-ring sequencer.
// Signals:
//   vdd_ok_async, vddio_ok_async - raw rail power-good indications (asynchronous)
//   req_on                       - level request to power the ring up
//   fault_clr                    - single-cycle fault clear pulse
//   io_iso, io_pad_en, pwr_ready - ring control outputs from the sequencer
//   fault                        - sticky rail-loss flag
//   state                        - sequencer state for debug/status
// Modports: master = controller side, slave = sequencer side.
interface io_ring_pwr_seq_if;
  import io_ring_pkg::*;

  logic          vdd_ok_async;
  logic          vddio_ok_async;
  logic          req_on;
  logic          fault_clr;
  logic          io_iso;
  logic          io_pad_en;
  logic          pwr_ready;
  logic          fault;
  io_seq_state_e state;

  modport master (
    output vdd_ok_async,
    output vddio_ok_async,
    output req_on,
    output fault_clr,
    input  io_iso,
    input  io_pad_en,
    input  pwr_ready,
    input  fault,
    input  state
  );

  modport slave (
    input  vdd_ok_async,
    input  vddio_ok_async,
    input  req_on,
    input  fault_clr,
    output io_iso,
    output io_pad_en,
    output pwr_ready,
    output fault,
    output state
  );

endinterface

// File: rtl/io_ring_sync.sv
// N-flop synchroniser for a single asynchronous level, synchronously reset to 0.
// Ports:
//   clk_i - destination clock
//   rst_i - synchronous active-high reset, clears every stage
//   d_i   - asynchronous input level
//   q_o   - synchronised level, STAGES clocks behind d_i
module io_ring_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/io_ring_pwr_seq.sv
// IO-ring power sequencer. Qualifies both rail power-good signals, then sequences the ring
// up (release isolation, enable pads, report ready) and down in mirror order. Any rail
// loss once isolation has been released forces the safe state immediately and latches a
// fault until it is cleared with req_on low.
// Ports:
//   clk  - block clock
//   rst  - synchronous active-high reset
//   bus  - io_ring_pwr_seq_if.slave: rail-good inputs, req_on, fault_clr, ring outputs,
//          fault flag and state; every output is registered.
module io_ring_pwr_seq
  import io_ring_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = IO_SEQ_STABLE_CYCLES,
  parameter int unsigned STEP_CYCLES   = IO_SEQ_STEP_CYCLES
) (
  input logic              clk,
  input logic              rst,
  io_ring_pwr_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(max_u(STABLE_CYCLES, STEP_CYCLES));
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] StepLast   = CntW'(STEP_CYCLES - 1);

  if (SYNC_STAGES < IO_SEQ_SYNC_STAGES_MIN || SYNC_STAGES > IO_SEQ_SYNC_STAGES_MAX)
  begin : gen_bad_sync_stages
    $error("io_ring_pwr_seq: SYNC_STAGES out of range");
  end
  if (STABLE_CYCLES < 2) begin : gen_bad_stable_cycles
    $error("io_ring_pwr_seq: STABLE_CYCLES must be at least 2");
  end
  if (STEP_CYCLES < 1) begin : gen_bad_step_cycles
    $error("io_ring_pwr_seq: STEP_CYCLES must be at least 1");
  end

  logic vdd_ok;
  logic vddio_ok;
  logic rails_ok;
  logic rail_loss;

  io_seq_state_e   state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic            io_iso_q;
  logic            io_pad_en_q;
  logic            pwr_ready_q;
  logic            fault_q;

  io_ring_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync_vdd (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (bus.vdd_ok_async),
    .q_o  (vdd_ok)
  );

  io_ring_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync_vddio (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (bus.vddio_ok_async),
    .q_o  (vddio_ok)
  );

  always_comb begin
    rails_ok = vdd_ok & vddio_ok;
    // Rails are only trusted once isolation has been released; a drop during debounce is
    // just an unqualified rail and returns to OFF without a fault.
    rail_loss = !rails_ok && (state_q inside {StRelIso, StEnPads, StOn, StShutdown});
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StOff;
      cnt_q       <= '0;
      io_iso_q    <= 1'b1;
      io_pad_en_q <= 1'b0;
      pwr_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else if (rail_loss) begin
      // Hard drop to the safe state, no stepped shutdown.
      state_q     <= StFault;
      cnt_q       <= '0;
      io_iso_q    <= 1'b1;
      io_pad_en_q <= 1'b0;
      pwr_ready_q <= 1'b0;
      fault_q     <= 1'b1;
    end else begin
      cnt_q <= cnt_inc;
      unique case (state_q)
        StOff: begin
          if (bus.req_on && rails_ok) begin
            state_q <= StDebounce;
            cnt_q   <= '0;
          end
        end
        StDebounce: begin
          if (!rails_ok || !bus.req_on) begin
            state_q <= StOff;
            cnt_q   <= '0;
          end else if (cnt_q == StableLast) begin
            state_q  <= StRelIso;
            cnt_q    <= '0;
            io_iso_q <= 1'b0;
          end
        end
        StRelIso: begin
          if (cnt_q == StepLast) begin
            state_q     <= StEnPads;
            cnt_q       <= '0;
            io_pad_en_q <= 1'b1;
          end
        end
        StEnPads: begin
          if (cnt_q == StepLast) begin
            state_q     <= StOn;
            cnt_q       <= '0;
            pwr_ready_q <= 1'b1;
          end
        end
        StOn: begin
          if (!bus.req_on) begin
            state_q     <= StShutdown;
            cnt_q       <= '0;
            io_pad_en_q <= 1'b0;
            pwr_ready_q <= 1'b0;
          end
        end
        StShutdown: begin
          // A re-request here is ignored; the ring always lands in OFF first.
          if (cnt_q == StepLast) begin
            state_q  <= StOff;
            cnt_q    <= '0;
            io_iso_q <= 1'b1;
          end
        end
        StFault: begin
          if (bus.fault_clr && !bus.req_on) begin
            state_q <= StOff;
            cnt_q   <= '0;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StOff;
          cnt_q       <= '0;
          io_iso_q    <= 1'b1;
          io_pad_en_q <= 1'b0;
          pwr_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.io_iso    = io_iso_q;
  assign bus.io_pad_en = io_pad_en_q;
  assign bus.pwr_ready = pwr_ready_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Testbench for io_ring_pwr_seq with SYNC_STAGES=2, STABLE_CYCLES=8, STEP_CYCLES=4.
// Directed scenarios check fixed edge-by-edge expectations; a randomized run is checked
// against a phase/dwell reference model.
module tb_io_ring_pwr_seq;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int STEP   = 4;

  localparam int P_OFF = 0;
  localparam int P_DEB = 1;
  localparam int P_REL = 2;
  localparam int P_EN  = 3;
  localparam int P_ON  = 4;
  localparam int P_SHD = 5;
  localparam int P_FLT = 6;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model state: current phase, edges spent in it, history of raw rail samples.
  int   m_ph;
  int   m_dwell;
  bit   hist[$];

  io_ring_pwr_seq_if bus ();

  io_ring_pwr_seq #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .STEP_CYCLES  (STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Length of a timed phase, and where it leads once that time has elapsed.
  function automatic int seq_len(input int ph);
    case (ph)
      P_DEB:   return STABLE;
      P_REL:   return STEP;
      P_EN:    return STEP;
      P_SHD:   return STEP;
      default: return 0;
    endcase
  endfunction

  function automatic int seq_next(input int ph);
    case (ph)
      P_DEB:   return P_REL;
      P_REL:   return P_EN;
      P_EN:    return P_ON;
      default: return P_OFF;
    endcase
  endfunction

  function automatic bit exp_iso();
    return !(m_ph inside {P_REL, P_EN, P_ON, P_SHD});
  endfunction

  function automatic bit exp_pad();
    return m_ph inside {P_EN, P_ON};
  endfunction

  task automatic model_step();
    bit ok;
    bit req;
    int nxt;
    ok  = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
    req = bus.req_on;
    if (rst) begin
      hist.delete();
      hist.push_back(1'b0);
      m_ph    = P_OFF;
      m_dwell = 0;
      return;
    end
    hist.push_back(bus.vdd_ok_async && bus.vddio_ok_async);
    if (hist.size() > 8) void'(hist.pop_front());
    nxt = m_ph;
    if (!ok && (m_ph inside {P_REL, P_EN, P_ON, P_SHD})) begin
      nxt = P_FLT;
    end else begin
      case (m_ph)
        P_OFF: if (req && ok) nxt = P_DEB;
        P_DEB: begin
          if (!ok || !req) nxt = P_OFF;
          else if (m_dwell + 1 >= seq_len(m_ph)) nxt = seq_next(m_ph);
        end
        P_ON:  if (!req) nxt = P_SHD;
        P_FLT: if (bus.fault_clr && !req) nxt = P_OFF;
        default: if (m_dwell + 1 >= seq_len(m_ph)) nxt = seq_next(m_ph);
      endcase
    end
    m_dwell = (nxt != m_ph) ? 0 : m_dwell + 1;
    m_ph    = nxt;
  endtask

  // One clock: model sees the inputs the DUT will sample, outputs are read 1ns after.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.vdd_ok_async   = 1'b0;
    bus.vddio_ok_async = 1'b0;
    bus.req_on         = 1'b0;
    bus.fault_clr      = 1'b0;
    rst                = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic bring_up();
    bit reached;
    reached            = 1'b0;
    bus.vdd_ok_async   = 1'b1;
    bus.vddio_ok_async = 1'b1;
    bus.req_on         = 1'b1;
    for (int i = 0; i < 40 && !reached; i++) begin
      step();
      if (bus.state == 3'd4) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL bring_up_timeout state got=%0d required=4", bus.state);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.io_iso, bus.io_pad_en, bus.pwr_ready, bus.fault} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=1000",
               {bus.io_iso, bus.io_pad_en, bus.pwr_ready, bus.fault});
    end
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d required=0", bus.state);
    end
  endtask

  task automatic test_power_up();
    int es;
    do_reset();
    bus.vdd_ok_async   = 1'b1;
    bus.vddio_ok_async = 1'b1;
    bus.req_on         = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      es = (e < 3) ? 0 : (e < 11) ? 1 : (e < 15) ? 2 : (e < 19) ? 3 : 4;
      checks++;
      if (bus.state !== 3'(es)) begin
        errors++;
        $display("FAIL pu_state edge=%0d got=%0d required=%0d", e, bus.state, es);
      end
      checks++;
      if ({bus.io_iso, bus.io_pad_en, bus.pwr_ready, bus.fault} !==
          {1'(e < 11), 1'(e >= 15), 1'(e >= 19), 1'b0}) begin
        errors++;
        $display("FAIL pu_outputs edge=%0d got=%b required=%b", e,
                 {bus.io_iso, bus.io_pad_en, bus.pwr_ready, bus.fault},
                 {1'(e < 11), 1'(e >= 15), 1'(e >= 19), 1'b0});
      end
    end
  endtask

  task automatic test_debounce_glitch();
    int es;
    do_reset();
    bus.vdd_ok_async   = 1'b1;
    bus.vddio_ok_async = 1'b1;
    bus.req_on         = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      step();
      es = (e < 3) ? 0 : (e < 11) ? 1 : (e < 14) ? 0 : (e < 22) ? 1 :
           (e < 26) ? 2 : (e < 30) ? 3 : 4;
      checks++;
      if (bus.state !== 3'(es)) begin
        errors++;
        $display("FAIL glitch_state edge=%0d got=%0d required=%0d", e, bus.state, es);
      end
      checks++;
      if (bus.io_iso !== 1'(e < 22) || bus.fault !== 1'b0) begin
        errors++;
        $display("FAIL glitch_iso_fault edge=%0d got=%b%b required=%b0", e, bus.io_iso,
                 bus.fault, 1'(e < 22));
      end
      if (e == 8) bus.vddio_ok_async = 1'b0;
      if (e == 11) bus.vddio_ok_async = 1'b1;
    end
  endtask

  task automatic test_rail_loss();
    do_reset();
    bring_up();
    bus.vdd_ok_async = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (bus.state !== 3'd4 || bus.io_pad_en !== 1'b1) begin
        errors++;
        $display("FAIL loss_early edge=%0d state got=%0d pad=%b required=4 pad=1", k,
                 bus.state, bus.io_pad_en);
      end
    end
    step();
    checks++;
    if ({bus.io_iso, bus.io_pad_en, bus.pwr_ready, bus.fault} !== 4'b1001 ||
        bus.state !== 3'd6) begin
      errors++;
      $display("FAIL loss_fault outputs got=%b state=%0d required=1001 state=6",
               {bus.io_iso, bus.io_pad_en, bus.pwr_ready, bus.fault}, bus.state);
    end
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    step();
    checks++;
    if (bus.state !== 3'd6 || bus.fault !== 1'b1) begin
      errors++;
      $display("FAIL clr_ignored state got=%0d fault=%b required=6 fault=1", bus.state,
               bus.fault);
    end
    bus.req_on    = 1'b0;
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    checks++;
    if (bus.state !== 3'd0 || bus.fault !== 1'b0 || bus.io_iso !== 1'b1) begin
      errors++;
      $display("FAIL clr_accepted state got=%0d fault=%b iso=%b required=0 0 1", bus.state,
               bus.fault, bus.io_iso);
    end
  endtask

  task automatic test_power_down();
    do_reset();
    bring_up();
    bus.req_on = 1'b0;
    step();
    checks++;
    if ({bus.io_iso, bus.io_pad_en, bus.pwr_ready} !== 3'b000 || bus.state !== 3'd5) begin
      errors++;
      $display("FAIL pd_entry got=%b state=%0d required=000 state=5",
               {bus.io_iso, bus.io_pad_en, bus.pwr_ready}, bus.state);
    end
    // Re-request mid-shutdown must not reverse the sequence.
    bus.req_on = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (bus.state !== 3'd5 || bus.io_iso !== 1'b0) begin
        errors++;
        $display("FAIL pd_dwell k=%0d state got=%0d iso=%b required=5 0", k, bus.state,
                 bus.io_iso);
      end
    end
    step();
    checks++;
    if (bus.state !== 3'd0 || bus.io_iso !== 1'b1 || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL pd_done state got=%0d iso=%b fault=%b required=0 1 0", bus.state,
               bus.io_iso, bus.fault);
    end
    step();
    checks++;
    if (bus.state !== 3'd1) begin
      errors++;
      $display("FAIL pd_rerequest state got=%0d required=1", bus.state);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bring_up();
    bus.vdd_ok_async = 1'b0;
    step();
    step();
    bus.req_on = 1'b0;
    step();
    checks++;
    if (bus.state !== 3'd6 || bus.fault !== 1'b1 || bus.io_iso !== 1'b1) begin
      errors++;
      $display("FAIL simul_priority state got=%0d fault=%b iso=%b required=6 1 1", bus.state,
               bus.fault, bus.io_iso);
    end
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL simul_clear state got=%0d required=0", bus.state);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.vdd_ok_async   = 1'b1;
    bus.vddio_ok_async = 1'b1;
    bus.req_on         = 1'b1;
    for (int e = 1; e <= 16; e++) step();
    checks++;
    if (bus.state !== 3'd3) begin
      errors++;
      $display("FAIL mid_precond state got=%0d required=3", bus.state);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.io_iso, bus.io_pad_en, bus.pwr_ready, bus.fault} !== 4'b1000 ||
        bus.state !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset got=%b state=%0d required=1000 state=0",
               {bus.io_iso, bus.io_pad_en, bus.pwr_ready, bus.fault}, bus.state);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if (bus.vdd_ok_async) bus.vdd_ok_async = ($urandom_range(0, 199) != 0);
      else bus.vdd_ok_async = ($urandom_range(0, 3) == 0);
      if (bus.vddio_ok_async) bus.vddio_ok_async = ($urandom_range(0, 199) != 0);
      else bus.vddio_ok_async = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) bus.req_on = !bus.req_on;
      bus.fault_clr = ($urandom_range(0, 9) == 0);
      step();
      checks++;
      if (bus.state !== 3'(m_ph)) begin
        errors++;
        $display("FAIL rnd_state cyc=%0d got=%0d required=%0d", i, bus.state, m_ph);
      end
      checks++;
      if (bus.io_iso !== exp_iso()) begin
        errors++;
        $display("FAIL rnd_iso cyc=%0d got=%b required=%b", i, bus.io_iso, exp_iso());
      end
      checks++;
      if (bus.io_pad_en !== exp_pad()) begin
        errors++;
        $display("FAIL rnd_pad cyc=%0d got=%b required=%b", i, bus.io_pad_en, exp_pad());
      end
      checks++;
      if (bus.pwr_ready !== 1'(m_ph == P_ON)) begin
        errors++;
        $display("FAIL rnd_ready cyc=%0d got=%b required=%b", i, bus.pwr_ready,
                 1'(m_ph == P_ON));
      end
      checks++;
      if (bus.fault !== 1'(m_ph == P_FLT)) begin
        errors++;
        $display("FAIL rnd_fault cyc=%0d got=%b required=%b", i, bus.fault,
                 1'(m_ph == P_FLT));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_ph    = P_OFF;
    m_dwell = 0;
    rst     = 1'b1;
    test_reset();
    test_power_up();
    test_debounce_glitch();
    test_rail_loss();
    test_power_down();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
